// File: rtl/lu_wb_queue.sv
// Writeback queue behind the 64-bit logic unit: in-order FIFO of {tag, result} drained to one RF write port.
// Optional operand forwarding of pending results is compiled in with `define LU_WB_FWD_EN.
module lu_wb_queue #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [5:0]                 in_sel,
  input  logic [DATA_W-1:0]          in_result,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       wr_en,
  input  logic                       wr_grant,
  output logic [TAG_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       illegal_op,
  input  logic [TAG_W-1:0]           fwd_tag,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              illegal_q, illegal_d;
  logic [TAG_W-1:0]  tag_mem_q  [DEPTH];
  logic [TAG_W-1:0]  tag_mem_d  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];

  logic legal_s;
  logic push_s;
  logic pop_s;

  // Logic-unit group is 6'b100000..6'b100111; anything else completes the handshake but is dropped.
  assign legal_s  = (in_sel >= 6'b100000) && (in_sel <= 6'b100111);
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign wr_en    = (count_q != {CNT_W{1'b0}});
  assign push_s   = in_valid & in_ready & legal_s;
  assign pop_s    = wr_en & wr_grant;

  assign wr_addr    = wr_en ? tag_mem_q[head_q]  : {TAG_W{1'b0}};
  assign wr_data    = wr_en ? data_mem_q[head_q] : {DATA_W{1'b0}};
  assign count      = count_q;
  assign illegal_op = illegal_q;

  // Next-state for pointers, occupancy, storage and the illegal-opcode pulse.
  always_comb begin
    tag_mem_d  = tag_mem_q;
    data_mem_d = data_mem_q;
    illegal_d  = in_valid & in_ready & ~legal_s;

    if (push_s) begin
      tag_mem_d[tail_q]  = in_tag;
      data_mem_d[tail_q] = in_result;
      tail_d             = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared too so outputs never carry X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= {PTR_W{1'b0}};
      tail_q    <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      illegal_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i]  <= {TAG_W{1'b0}};
        data_mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      illegal_q  <= illegal_d;
      tag_mem_q  <= tag_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

`ifdef LU_WB_FWD_EN
  logic [PTR_W-1:0] fwd_idx_s;

  // Youngest-first scan of occupied slots; an entry popping this cycle is still pending.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = {DATA_W{1'b0}};
    fwd_idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = tail_q - PTR_W'(i + 1);
      if (!fwd_hit && (CNT_W'(i) < count_q) && (tag_mem_q[fwd_idx_s] == fwd_tag)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem_q[fwd_idx_s];
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end
  end
`else
  logic fwd_tag_unused;

  assign fwd_tag_unused = ^fwd_tag;
  assign fwd_hit        = 1'b0;
  assign fwd_data       = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_lu_wb_queue.sv
// Bench for lu_wb_queue: vector table with expected occupancy plus a queue scoreboard checked every cycle.
// Forwarding expectations follow the LU_WB_FWD_EN build macro.
module tb_lu_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_sel;
  logic [63:0] in_result;
  logic [4:0]  in_tag;
  logic        wr_en;
  logic        wr_grant;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [2:0]  count;
  logic        illegal_op;
  logic [4:0]  fwd_tag;
  logic        fwd_hit;
  logic [63:0] fwd_data;

  lu_wb_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_result(in_result), .in_tag(in_tag),
    .wr_en(wr_en), .wr_grant(wr_grant), .wr_addr(wr_addr), .wr_data(wr_data),
    .count(count), .illegal_op(illegal_op),
    .fwd_tag(fwd_tag), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tag;
    logic [63:0] data;
  } ent_t;

  typedef struct {
    logic        v;
    logic [5:0]  sel;
    logic [4:0]  tag;
    logic [63:0] data;
    logic        g;
    int          cnt;
    logic        ill;
  } vec_t;

  ent_t        sb_q[$];
  logic        m_ill;
  logic [4:0]  drain_log[$];
  vec_t        vecs[$];
  int          pass_cnt = 0;
  int          tot_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic legal(input logic [5:0] s);
    return (s[5:3] == 3'b100);
  endfunction

  // One clock: drive at negedge, compare against the scoreboard, update it across the edge.
  task automatic cycle(input logic v, input logic [5:0] s, input logic [4:0] t,
                       input logic [63:0] d, input logic g, input logic [4:0] ft);
    logic        e_rdy;
    logic        e_hit;
    logic [63:0] e_fd;
    in_valid = v; in_sel = s; in_tag = t; in_result = d; wr_grant = g; fwd_tag = ft;
    #1;
    e_rdy = (sb_q.size() < 4);
    e_hit = 1'b0;
    e_fd  = 64'h0;
`ifdef LU_WB_FWD_EN
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (!e_hit && sb_q[i].tag == ft) begin
        e_hit = 1'b1;
        e_fd  = sb_q[i].data;
      end
    end
`endif
    chk("in_ready", {63'h0, in_ready}, {63'h0, e_rdy});
    chk("wr_en", {63'h0, wr_en}, {63'h0, (sb_q.size() != 0)});
    chk("count", {61'h0, count}, 64'(sb_q.size()));
    chk("illegal_op", {63'h0, illegal_op}, {63'h0, m_ill});
    chk("fwd_hit", {63'h0, fwd_hit}, {63'h0, e_hit});
    chk("fwd_data", fwd_data, e_fd);
    if (sb_q.size() != 0) begin
      chk("wr_addr", {59'h0, wr_addr}, {59'h0, sb_q[0].tag});
      chk("wr_data", wr_data, sb_q[0].data);
      if (g) begin
        drain_log.push_back(wr_addr);
        void'(sb_q.pop_front());
      end
    end else begin
      chk("wr_addr_idle", {59'h0, wr_addr}, 64'h0);
      chk("wr_data_idle", wr_data, 64'h0);
    end
    if (v && e_rdy && legal(s)) sb_q.push_back('{t, d});
    m_ill = v && e_rdy && !legal(s);
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [4:0] exp_log[$];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 6'h0; in_result = 64'h0; in_tag = 5'h0;
    wr_grant = 1'b0; fwd_tag = 5'h0; m_ill = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // inputs and expected {count, illegal_op} once the cycle's edge has passed
    vecs.push_back('{1'b0, 6'h00, 5'd0,  64'h0,    1'b0, 0, 1'b0});
    vecs.push_back('{1'b1, 6'h20, 5'd3,  64'h00FF, 1'b0, 1, 1'b0});
    vecs.push_back('{1'b0, 6'h00, 5'd0,  64'h0,    1'b1, 0, 1'b0});
    for (int i = 1; i <= 4; i++)
      vecs.push_back('{1'b1, 6'(6'h20 + i), 5'(i), 64'(64'h100 + i), 1'b0, i, 1'b0});
    vecs.push_back('{1'b1, 6'h21, 5'd5,  64'h555,  1'b0, 4, 1'b0});
    for (int i = 3; i >= 0; i--)
      vecs.push_back('{1'b0, 6'h00, 5'd0,  64'h0,  1'b1, i, 1'b0});
    vecs.push_back('{1'b1, 6'h26, 5'd10, 64'hA10,  1'b0, 1, 1'b0});
    vecs.push_back('{1'b1, 6'h27, 5'd11, 64'hA11,  1'b0, 2, 1'b0});
    vecs.push_back('{1'b1, 6'h22, 5'd7,  64'h777,  1'b1, 2, 1'b0});
    for (int i = 12; i <= 16; i++)
      vecs.push_back('{1'b1, 6'h23, 5'(i), 64'(64'hC00 + i), 1'b1, 2, 1'b0});
    vecs.push_back('{1'b0, 6'h00, 5'd0,  64'h0,    1'b1, 1, 1'b0});
    vecs.push_back('{1'b0, 6'h00, 5'd0,  64'h0,    1'b1, 0, 1'b0});
    vecs.push_back('{1'b1, 6'h0A, 5'd9,  64'h999,  1'b0, 0, 1'b1});
    vecs.push_back('{1'b0, 6'h00, 5'd0,  64'h0,    1'b0, 0, 1'b0});

    foreach (vecs[k]) begin
      cycle(vecs[k].v, vecs[k].sel, vecs[k].tag, vecs[k].data, vecs[k].g, 5'd31);
      chk("vec_count", {61'h0, count}, 64'(vecs[k].cnt));
      chk("vec_illegal", {63'h0, illegal_op}, {63'h0, vecs[k].ill});
    end

    exp_log = '{5'd3, 5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 5'd11, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
    chk("drain_len", 64'(drain_log.size()), 64'(exp_log.size()));
    foreach (exp_log[k])
      if (k < drain_log.size()) chk("drain_order", {59'h0, drain_log[k]}, {59'h0, exp_log[k]});

    // Forwarding: two pending writes to tag 5, the younger one wins.
    cycle(1'b1, 6'h24, 5'd5, 64'hA, 1'b0, 5'd5);
    cycle(1'b1, 6'h25, 5'd5, 64'hB, 1'b0, 5'd5);
    cycle(1'b0, 6'h00, 5'd0, 64'h0, 1'b0, 5'd5);
`ifdef LU_WB_FWD_EN
    chk("fwd_hit_tag5", {63'h0, fwd_hit}, 64'h1);
    chk("fwd_data_tag5", fwd_data, 64'hB);
`else
    chk("fwd_hit_off", {63'h0, fwd_hit}, 64'h0);
    chk("fwd_data_off", fwd_data, 64'h0);
`endif
    cycle(1'b0, 6'h00, 5'd0, 64'h0, 1'b0, 5'd6);
    chk("fwd_hit_tag6", {63'h0, fwd_hit}, 64'h0);
    chk("fwd_data_tag6", fwd_data, 64'h0);
    // Pending entry popping this cycle still forwards.
    cycle(1'b0, 6'h00, 5'd0, 64'h0, 1'b1, 5'd5);
    cycle(1'b0, 6'h00, 5'd0, 64'h0, 1'b1, 5'd5);

    // Illegal opcode while full: no handshake, so no pulse.
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'h20, 5'(20 + i), 64'(64'hF0 + i), 1'b0, 5'd20);
    cycle(1'b1, 6'h3F, 5'd9, 64'h9, 1'b0, 5'd0);
    chk("illegal_full", {63'h0, illegal_op}, 64'h0);
    cycle(1'b0, 6'h00, 5'd0, 64'h0, 1'b1, 5'd0);

    // Asynchronous reset with three entries pending.
    chk("pre_reset_count", {61'h0, count}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", {61'h0, count}, 64'h0);
    chk("rst_wr_en", {63'h0, wr_en}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_wr_addr", {59'h0, wr_addr}, 64'h0);
    chk("rst_wr_data", wr_data, 64'h0);
    chk("rst_fwd_hit", {63'h0, fwd_hit}, 64'h0);
    sb_q.delete();
    m_ill = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 6'h00, 5'd0, 64'h0, 1'b1, 5'd20);
    cycle(1'b1, 6'h27, 5'd0, 64'h1234, 1'b0, 5'd0);
    cycle(1'b0, 6'h00, 5'd0, 64'h0, 1'b1, 5'd0);
    cycle(1'b0, 6'h00, 5'd0, 64'h0, 1'b0, 5'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
